// File: rtl/data_mem_responder.sv
// Responder side of the CPU data-memory interface: word RAM plus an MMIO page
// holding a free-running cycle counter, a TX FIFO drained over a valid/ready
// stream port, a status register and a control register.
module data_mem_responder #(
    parameter int MEM_WORDS  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:0] address_to_mem,
    input  logic [31:0] data_to_mem,
    output logic [31:0] data_from_mem,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    localparam logic [15:0] OFF_CYCLES = 16'h0000;
    localparam logic [15:0] OFF_TXDATA = 16'h0004;
    localparam logic [15:0] OFF_STATUS = 16'h0008;
    localparam logic [15:0] OFF_CTRL   = 16'h000C;

    logic [31:0]   ram [MEM_WORDS];
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] ram_idx;
    logic          is_mmio;
    logic [15:0]   offset;

    logic [31:0]   cycles;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic          full;
    logic          empty;
    logic          flush;
    logic          clr_ovf;
    logic          pop;
    logic          push;
    logic          drop;
    logic [31:0]   status;

    assign ram_idx   = address_to_mem[AW+1:2];
    assign is_mmio   = (address_to_mem[31:16] == 16'hFFFF);
    assign offset    = address_to_mem[15:0];
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign out_valid = !empty;
    assign out_data  = fifo_mem[rd_ptr];

    // Decode MMIO writes and resolve the push/pop/drop interactions of the FIFO.
    always_comb begin
        logic txdata_wr;
        logic ctrl_wr;
        txdata_wr = !reset && WE && is_mmio && (offset == OFF_TXDATA);
        ctrl_wr   = !reset && WE && is_mmio && (offset == OFF_CTRL);
        flush     = ctrl_wr && data_to_mem[1];
        clr_ovf   = ctrl_wr && data_to_mem[0];
        // A flush voids any pop in the same cycle.
        pop       = !reset && out_valid && out_ready && !flush;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push      = txdata_wr && (!full || pop);
        drop      = txdata_wr && full && !pop;
    end

    // Pack the status word from pre-edge FIFO state.
    always_comb begin
        status      = '0;
        status[0]   = full;
        status[1]   = empty;
        status[2]   = overflow;
        status[7:4] = 4'(count);
    end

    // Combinational read mux; depends only on address and registered state.
    always_comb begin
        data_from_mem = '0;
        if (is_mmio) begin
            case (offset)
                OFF_CYCLES: data_from_mem = cycles;
                OFF_STATUS: data_from_mem = status;
                default:    data_from_mem = '0;
            endcase
        end else begin
            data_from_mem = ram[ram_idx];
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (WE && !is_mmio) begin
            ram[ram_idx] <= data_to_mem;
        end
    end

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycles <= '0;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= data_to_mem;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
            if (clr_ovf) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus queues expected read data
// and expected stream words; independent monitors pop and compare them.
module tb_data_mem_responder;

    localparam int MEM_WORDS = 256;
    localparam logic [31:0] A_CYCLES = 32'hFFFF_0000;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_0004;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
    localparam logic [31:0] A_CTRL   = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        WE = 1'b0;
    logic [31:0] address_to_mem = '0;
    logic [31:0] data_to_mem = '0;
    logic [31:0] data_from_mem;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_q [$];
    string       rd_name_q [$];
    logic [31:0] st_q [$];
    logic        rd_strobe = 1'b0;

    logic [31:0] cyc_model = '0;
    logic [31:0] cyc_bias = '0;

    data_mem_responder #(.MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .WE(WE),
        .address_to_mem(address_to_mem),
        .data_to_mem(data_to_mem),
        .data_from_mem(data_from_mem),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Reference cycle counter.
    always @(posedge clk) begin
        if (reset) cyc_model <= '0;
        else       cyc_model <= cyc_model + 32'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read-data monitor.
    always @(negedge clk) begin
        if (rd_strobe) begin
            if (rd_q.size() == 0) begin
                chk("rd_queue_underflow", 32'd1, 32'd0);
            end else begin
                chk(rd_name_q.pop_front(), data_from_mem, rd_q.pop_front());
            end
        end
    end

    // Stream monitor: a transfer happens when valid&ready, unless reset or flush.
    always @(negedge clk) begin
        if (out_valid && out_ready && !reset &&
            !(WE && address_to_mem == A_CTRL && data_to_mem[1])) begin
            if (st_q.size() == 0) begin
                chk("stream_unexpected", out_data, 32'hxxxx_xxxx);
            end else begin
                chk("stream_word", out_data, st_q.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic check, input logic [31:0] exp, input string name);
        WE = we;
        address_to_mem = addr;
        data_to_mem = data;
        if (check) begin
            rd_q.push_back(exp);
            rd_name_q.push_back(name);
            rd_strobe = 1'b1;
        end
        tick();
        WE = 1'b0;
        rd_strobe = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        access(1'b1, addr, data, 1'b0, '0, "");
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        access(1'b0, addr, '0, 1'b1, exp, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        rd(A_CYCLES, 32'd0, "reset_cycles");
        rd(A_STATUS, 32'h02, "reset_status");

        // RAM: write, alias, ignored low bits, old data on same-cycle write
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, 32'hDEAD_BEEF, "ram_read");
        rd(32'h10 + 4 * MEM_WORDS, 32'hDEAD_BEEF, "ram_alias");
        rd(32'h13, 32'hDEAD_BEEF, "ram_low_bits");
        wr(32'h20, 32'h1111_1111);
        access(1'b1, 32'h20, 32'h2222_2222, 1'b1, 32'h1111_1111, "ram_rw_old");
        rd(32'h20, 32'h2222_2222, "ram_rw_new");

        // MMIO isolation and write-only / unmapped reads
        wr(32'hFFFF_0010, 32'h5555_AAAA);
        rd(32'h10, 32'hDEAD_BEEF, "mmio_no_ram_write");
        rd(32'hFFFF_0010, 32'd0, "mmio_unmapped");
        rd(A_TXDATA, 32'd0, "txdata_read");
        rd(A_CTRL, 32'd0, "ctrl_read");

        // Mid-run reset
        wr(A_TXDATA, 32'hAA);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        rd(A_CYCLES, 32'd0, "midreset_cycles");
        rd(A_STATUS, 32'h02, "midreset_status");
        rd(32'h10, 32'hDEAD_BEEF, "midreset_ram_kept");

        // FIFO ordering, full and overflow
        for (int i = 1; i <= 4; i++) begin
            wr(A_TXDATA, 32'(i));
            st_q.push_back(32'(i));
        end
        rd(A_STATUS, 32'h41, "status_full");
        wr(A_TXDATA, 32'd5);
        rd(A_STATUS, 32'h45, "status_overflow");
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("drained_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Overflow clear
        wr(A_CTRL, 32'h1);
        rd(A_STATUS, 32'h02, "ovf_cleared");

        // Push into a full FIFO while popping
        for (int i = 1; i <= 4; i++) begin
            wr(A_TXDATA, 32'(i));
            st_q.push_back(32'(i));
        end
        out_ready = 1'b1;
        st_q.push_back(32'd9);
        wr(A_TXDATA, 32'd9);
        for (int i = 0; i < 4; i++) tick();
        rd(A_STATUS, 32'h02, "fullpop_no_ovf");
        out_ready = 1'b0;

        // Flush with a concurrent ready: no pop
        for (int i = 1; i <= 3; i++) wr(A_TXDATA, 32'(16 + i));
        rd(A_STATUS, 32'h30, "status_count3");
        out_ready = 1'b1;
        wr(A_CTRL, 32'h2);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        rd(A_STATUS, 32'h02, "flush_status");
        out_ready = 1'b0;

        // Cycle counter spacing
        rd(A_CYCLES, cyc_model + cyc_bias, "cycles_a");
        for (int i = 0; i < 5; i++) tick();
        rd(A_CYCLES, cyc_model + cyc_bias, "cycles_b");

        // Cycle counter wrap
        cyc_bias = 32'hFFFF_FFFF - cyc_model;
        force dut.cycles = 32'hFFFF_FFFF;
        #1;
        release dut.cycles;
        rd(A_CYCLES, cyc_model + cyc_bias, "cycles_max");
        rd(A_CYCLES, cyc_model + cyc_bias, "cycles_wrap");

        begin
            int budget = 50;
            while (st_q.size() != 0 && budget > 0) begin
                tick();
                budget--;
            end
        end
        chk("stream_leftover", 32'(st_q.size()), 32'd0);
        chk("rd_leftover", 32'(rd_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
